// File: rtl/systolic_pkg.sv
// ============================================================================
// systolic_pkg
// Shared types and sizing helpers for the systolic matrix-multiply engine.
// Revision: 1.0
// ============================================================================
`default_nettype none

package systolic_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        DRAIN = 2'd2,
        OUT   = 2'd3
    } state_t;

    // Cycles for the last beat to cross the skewed array diagonal.
    function automatic int drain_cycles(input int n);
        return 2 * (n - 1) + 1;
    endfunction

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/systolic_pe_mac.sv
// ============================================================================
// systolic_pe_mac
// One processing element: registered operand pass-through plus CW accumulator.
// Revision: 1.0
// ============================================================================
`default_nettype none

module systolic_pe_mac
    import systolic_pkg::*;
#(
    parameter int DW = 8,
    parameter int CW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          signed_mode,
    input  logic [DW-1:0] a_in,
    input  logic [DW-1:0] b_in,
    output logic [DW-1:0] a_out,
    output logic [DW-1:0] b_out,
    output logic [CW-1:0] acc
);

    logic [DW-1:0]          a_q, b_q;
    logic [CW-1:0]          acc_q, acc_d;
    logic signed [DW:0]     a_ext, b_ext;
    logic signed [2*DW+1:0] prod;

    // One extra bit per operand lets a single signed multiplier cover both modes.
    assign a_ext = {signed_mode & a_in[DW-1], a_in};
    assign b_ext = {signed_mode & b_in[DW-1], b_in};
    assign prod  = a_ext * b_ext;

    always_comb begin
        acc_d = clear ? '0 : acc_q + CW'(prod);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q   <= '0;
            b_q   <= '0;
            acc_q <= '0;
        end else begin
            a_q   <= a_in;
            b_q   <= b_in;
            acc_q <= acc_d;
        end
    end

    assign a_out = a_q;
    assign b_out = b_q;
    assign acc   = acc_q;

endmodule

`default_nettype wire

// File: rtl/systolic_matmul_engine.sv
// ============================================================================
// systolic_matmul_engine
// Output-stationary NxN systolic matmul with operand skew, control FSM, streams.
// Revision: 1.0
// ============================================================================
`default_nettype none

module systolic_matmul_engine
    import systolic_pkg::*;
#(
    parameter int N  = 4,
    parameter int DW = 8,
    parameter int CW = 32,
    parameter int KW = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [KW-1:0]        k_len,
    input  logic                 signed_mode,
    output logic                 busy,
    output logic                 done,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [N*DW-1:0]      a_vec,
    input  logic [N*DW-1:0]      b_vec,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [N*CW-1:0]      out_row,
    output logic [idx_w(N)-1:0]  out_row_idx
);

    localparam int DRAIN_CYCLES = drain_cycles(N);
    localparam int DCW          = idx_w(DRAIN_CYCLES);
    localparam int IW           = idx_w(N);

    state_t         state_q, state_d;
    logic [KW-1:0]  k_len_q, k_len_d, beat_q, beat_d;
    logic           signed_q, signed_d, done_q, done_d;
    logic [DCW-1:0] drain_q, drain_d;
    logic [IW-1:0]  row_q, row_d;
    logic           accept, clear;

    logic [DW-1:0]  a_inj [N], b_inj [N], a_edge [N], b_edge [N];
    logic [DW-1:0]  a_h [N][N-1], b_v [N-1][N];
    logic [DW-1:0]  a_out_unused [N], b_out_unused [N];
    logic [CW-1:0]  acc [N][N];

    assign accept = (state_q == LOAD) && in_valid;
    assign clear  = (state_q == IDLE) && start;

    always_comb begin
        state_d  = state_q;
        k_len_d  = k_len_q;
        signed_d = signed_q;
        beat_d   = beat_q;
        drain_d  = drain_q;
        row_d    = row_q;
        done_d   = 1'b0;
        case (state_q)
            IDLE: if (start) begin
                k_len_d  = k_len;
                signed_d = signed_mode;
                beat_d   = '0;
                drain_d  = '0;
                row_d    = '0;
                state_d  = (k_len == '0) ? OUT : LOAD;
            end
            LOAD: if (accept) begin
                beat_d = beat_q + KW'(1);
                if (beat_q == k_len_q - KW'(1)) begin
                    state_d = DRAIN;
                    drain_d = '0;
                end
            end
            DRAIN: begin
                if (drain_q == DCW'(DRAIN_CYCLES - 1)) begin
                    state_d = OUT;
                    row_d   = '0;
                end else begin
                    drain_d = drain_q + DCW'(1);
                end
            end
            OUT: if (out_ready) begin
                if (row_q == IW'(N - 1)) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                    row_d   = '0;
                end else begin
                    row_d = row_q + IW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            k_len_q  <= '0;
            signed_q <= 1'b0;
            beat_q   <= '0;
            drain_q  <= '0;
            row_q    <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            k_len_q  <= k_len_d;
            signed_q <= signed_d;
            beat_q   <= beat_d;
            drain_q  <= drain_d;
            row_q    <= row_d;
            done_q   <= done_d;
        end
    end

    // Lane i is delayed i registers; non-accepted cycles inject zeros.
    for (genvar i = 0; i < N; i++) begin : g_skew
        assign a_inj[i] = accept ? a_vec[i*DW +: DW] : '0;
        assign b_inj[i] = accept ? b_vec[i*DW +: DW] : '0;
        if (i == 0) begin : g_direct
            assign a_edge[i] = a_inj[i];
            assign b_edge[i] = b_inj[i];
        end else begin : g_chain
            logic [DW-1:0] a_sk_q [i];
            logic [DW-1:0] b_sk_q [i];
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int k = 0; k < i; k++) begin
                        a_sk_q[k] <= '0;
                        b_sk_q[k] <= '0;
                    end
                end else begin
                    a_sk_q[0] <= a_inj[i];
                    b_sk_q[0] <= b_inj[i];
                    for (int k = 1; k < i; k++) begin
                        a_sk_q[k] <= a_sk_q[k-1];
                        b_sk_q[k] <= b_sk_q[k-1];
                    end
                end
            end
            assign a_edge[i] = a_sk_q[i-1];
            assign b_edge[i] = b_sk_q[i-1];
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_row
        for (genvar j = 0; j < N; j++) begin : g_col
            logic [DW-1:0] a_in_w, b_in_w, a_out_w, b_out_w;
            if (j == 0) begin : g_a_edge
                assign a_in_w = a_edge[i];
            end else begin : g_a_int
                assign a_in_w = a_h[i][j-1];
            end
            if (i == 0) begin : g_b_edge
                assign b_in_w = b_edge[j];
            end else begin : g_b_int
                assign b_in_w = b_v[i-1][j];
            end
            if (j == N - 1) begin : g_a_last
                assign a_out_unused[i] = a_out_w;
            end else begin : g_a_pass
                assign a_h[i][j] = a_out_w;
            end
            if (i == N - 1) begin : g_b_last
                assign b_out_unused[j] = b_out_w;
            end else begin : g_b_pass
                assign b_v[i][j] = b_out_w;
            end
            systolic_pe_mac #(.DW(DW), .CW(CW)) u_pe (
                .clk         (clk),
                .rst         (rst),
                .clear       (clear),
                .signed_mode (signed_q),
                .a_in        (a_in_w),
                .b_in        (b_in_w),
                .a_out       (a_out_w),
                .b_out       (b_out_w),
                .acc         (acc[i][j])
            );
        end
    end

    always_comb begin
        out_row = '0;
        if (state_q == OUT) begin
            for (int j = 0; j < N; j++) begin
                out_row[j*CW +: CW] = acc[row_q][j];
            end
        end
    end

    assign busy        = (state_q != IDLE);
    assign in_ready    = (state_q == LOAD);
    assign out_valid   = (state_q == OUT);
    assign done        = done_q;
    assign out_row_idx = row_q;

endmodule

`default_nettype wire

// File: tb/tb_systolic_matmul_engine.sv
// ============================================================================
// tb_systolic_matmul_engine
// Directed self-checking bench for the systolic matmul engine.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_systolic_matmul_engine;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int CW = 32;
    localparam int KW = 16;
    localparam int KMAX = 8;

    logic              clk = 1'b0;
    logic              rst, start, signed_mode, in_valid, out_ready;
    logic [KW-1:0]     k_len;
    logic [N*DW-1:0]   a_vec, b_vec;
    logic              busy, done, in_ready, out_valid;
    logic [N*CW-1:0]   out_row;
    logic [1:0]        out_row_idx;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] mat_a [N][KMAX];
    logic [DW-1:0] mat_b [KMAX][N];
    logic [CW-1:0] exp_c [N][N];

    always #5 clk = ~clk;

    systolic_matmul_engine #(.N(N), .DW(DW), .CW(CW), .KW(KW)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .k_len       (k_len),
        .signed_mode (signed_mode),
        .busy        (busy),
        .done        (done),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .a_vec       (a_vec),
        .b_vec       (b_vec),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_row     (out_row),
        .out_row_idx (out_row_idx)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic fill_const(input logic [DW-1:0] av, input logic [DW-1:0] bv, input logic [CW-1:0] cv);
        for (int i = 0; i < N; i++)
            for (int k = 0; k < KMAX; k++) begin
                mat_a[i][k] = av;
                mat_b[k][i] = bv;
            end
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) exp_c[i][j] = cv;
    endtask

    // A = I, B[k][j] = 4k+j, so C = B.
    task automatic fill_identity();
        for (int i = 0; i < N; i++)
            for (int k = 0; k < KMAX; k++) begin
                mat_a[i][k] = (i == k) ? 8'd1 : 8'd0;
                mat_b[k][i] = 8'(k * 4 + i);
            end
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) exp_c[i][j] = 32'(i * 4 + j);
    endtask

    task automatic model(input int klen, input bit smode);
        logic [CW-1:0] s, p;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                s = '0;
                for (int k = 0; k < klen; k++) begin
                    if (smode) p = $signed(mat_a[i][k]) * $signed(mat_b[k][j]);
                    else       p = mat_a[i][k] * mat_b[k][j];
                    s = s + p;
                end
                exp_c[i][j] = s;
            end
    endtask

    // Called at a negedge; returns at a negedge with the engine idle.
    task automatic run_job(input int klen, input bit smode, input bit bubbles,
                           input int stall_row, input bit mid_start, input int exp_lat);
        int beat, m, r, stall, first;
        bit ph, done_seen, ir_checked;
        logic [127:0] er;
        beat = 0; m = 0; r = 0; stall = 0; first = -1;
        ph = 0; done_seen = 0; ir_checked = 0;
        start = 1'b1; k_len = KW'(klen); signed_mode = smode;
        while (m < 400 && !done_seen) begin
            @(negedge clk);
            m++;
            start       = (mid_start && m == 3);
            k_len       = KW'($urandom);
            signed_mode = $urandom_range(0, 1);
            in_valid    = 1'b0;
            a_vec       = $urandom;
            b_vec       = $urandom;
            out_ready   = 1'b1;
            if (in_ready && beat < klen) begin
                if (!(bubbles && ph)) begin
                    in_valid = 1'b1;
                    for (int i = 0; i < N; i++) begin
                        a_vec[i*DW +: DW] = mat_a[i][beat];
                        b_vec[i*DW +: DW] = mat_b[beat][i];
                    end
                    beat++;
                end
                ph = !ph;
            end
            if (done) begin
                done_seen = 1;
                check("done_after_rows", r, N);
                check("busy_at_done", busy, 0);
            end
            if (out_valid) begin
                if (first < 0) first = m;
                if (!ir_checked) begin
                    check("in_ready_in_out", in_ready, 0);
                    ir_checked = 1;
                end
                for (int j = 0; j < N; j++) er[j*CW +: CW] = exp_c[r % N][j];
                check("row_idx", out_row_idx, r % N);
                check("row_data", out_row, er);
                if (r == stall_row && stall < 3) begin
                    out_ready = 1'b0;
                    stall++;
                end else begin
                    r++;
                end
            end
        end
        start = 1'b0;
        if (!done_seen) check("job_timeout", 0, 1);
        if (exp_lat > 0) check("first_valid_latency", first, exp_lat);
        @(negedge clk);
        check("done_single_pulse", done, 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"},      busy, 0);
        check({tag, "_done"},      done, 0);
        check({tag, "_in_ready"},  in_ready, 0);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_out_row"},   out_row, 0);
        check({tag, "_row_idx"},   out_row_idx, 0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; k_len = '0; signed_mode = 1'b0;
        in_valid = 1'b0; a_vec = '0; b_vec = '0; out_ready = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        @(negedge clk);

        fill_identity();
        run_job(4, 1, 0, -1, 0, 0);

        fill_const(8'd127, 8'h80, 32'hFFFF0200);
        run_job(4, 1, 0, -1, 0, 0);

        fill_const(8'hFF, 8'hFF, 32'd260100);
        run_job(4, 0, 0, -1, 0, 0);

        fill_const(8'hFF, 8'hFF, 32'd4);
        run_job(4, 1, 0, -1, 0, 0);

        fill_identity();
        run_job(4, 1, 1, 1, 0, 0);

        fill_const(8'h5A, 8'hA5, 32'd0);
        run_job(0, 1, 0, -1, 0, 0);

        for (int i = 0; i < N; i++)
            for (int k = 0; k < KMAX; k++) begin
                mat_a[i][k] = DW'($urandom);
                mat_b[k][i] = DW'($urandom);
            end
        model(7, 1);
        run_job(7, 1, 0, -1, 1, 15);

        // Abort after two beats of all-ones data, then rerun identity.
        fill_const(8'hFF, 8'hFF, 32'd0);
        start = 1'b1; k_len = 16'd4; signed_mode = 1'b0;
        @(negedge clk);
        start = 1'b0;
        in_valid = 1'b1; a_vec = '1; b_vec = '1;
        @(negedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        check_reset_outputs("midload_rst");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        fill_identity();
        run_job(4, 1, 0, -1, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
